pcie_egress_arbiter: RTL and testbench
======================================

PCIE_EGRESS_ARBITER -- requirements
Module: pcie_egress_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, meaning number of requesters sharing the egress engine.
REQ-002 SHALL have parameter PRIO0, default 1, meaning requester 0 (completions) has strict priority when 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_req, input, NUM_REQ bits: per-requester transaction request, level.
REQ-006 SHALL have ports i_command / i_flags / i_address, inputs, NUM_REQ×8 / ×14 / ×32 bits: packed per-requester TLP header fields.
REQ-007 SHALL have ports i_requester_id / i_tag, inputs, NUM_REQ×16 / ×8 bits: packed per-requester header fields.
REQ-008 SHALL have ports i_fifo_rdy / i_fifo_size / i_fifo_data, inputs, NUM_REQ×1 / ×24 / ×32 bits: per-requester outgoing FIFO status and data.
REQ-009 SHALL have ports o_grant / o_done / o_fifo_act / o_fifo_stb, outputs, NUM_REQ bits each: per-requester grant, completion pulse, FIFO activate, FIFO strobe.
REQ-010 SHALL have ports o_eg_enable / i_eg_finished, output / input, 1 bit each: handshake to the egress engine.
REQ-011 SHALL have ports o_eg_command / o_eg_flags / o_eg_address / o_eg_requester_id / o_eg_tag, outputs, 8 / 14 / 32 / 16 / 8 bits: latched header to the engine.
REQ-012 SHALL have ports o_eg_fifo_rdy / o_eg_fifo_size / o_eg_fifo_data, outputs, 1 / 24 / 32 bits; i_eg_fifo_act / i_eg_fifo_stb, inputs, 1 bit each: FIFO path to and from the engine.
REQ-013 SHALL have port o_busy, output, 1 bit: arbiter is in a non-IDLE state.

Function
REQ-014 SHALL implement states IDLE, ACTIVE, DONE.
REQ-015 IDLE: when i_req is nonzero, SHALL select a winner (i_req[0] if PRIO0=1 and i_req[0]=1; otherwise round-robin starting at last_idx+1 and wrapping at NUM_REQ-1→0), latch its index and all header fields, then go to ACTIVE.
REQ-016 From the IDLE cycle that sees i_req, o_grant[idx], o_eg_enable, o_busy and the o_eg_* header fields SHALL be valid exactly 1 cycle later (registered).
REQ-017 ACTIVE: SHALL hold o_eg_enable=1 and the header stable until i_eg_finished=1, then go to DONE.
REQ-018 DONE: SHALL drop o_eg_enable, pulse o_done[idx] for exactly 1 cycle on entry, wait for i_eg_finished=0, set last_idx=idx, drop o_grant and return to IDLE.
REQ-019 The FIFO mux SHALL be combinational while not IDLE: o_eg_fifo_rdy=i_fifo_rdy[idx], o_eg_fifo_size/data from slice idx, o_fifo_act[idx]=i_eg_fifo_act, o_fifo_stb[idx]=i_eg_fifo_stb; all other requester bits SHALL be 0.
REQ-020 In IDLE all o_fifo_act/o_fifo_stb bits and o_eg_fifo_rdy SHALL be 0.
REQ-021 Header-field or i_req changes by the granted requester after the grant SHALL be ignored; the transaction SHALL complete.
REQ-022 i_eg_finished asserted while in IDLE SHALL be ignored.
REQ-023 At least one IDLE cycle SHALL separate consecutive grants; the same requester SHALL be regranted only if no other requester (and no priority requester 0) is requesting.

Reset
REQ-024 Asserting rst SHALL asynchronously force state=IDLE, last_idx=NUM_REQ-1 (so requester 0 wins first), and all outputs to 0, including mid-transaction.
REQ-025 The first grant after reset release SHALL occur no earlier than the first rising clk edge with rst=1.

Structure
REQ-026 The state encodings and the header field widths (8/14/32/16/8/24) SHALL live in the shared PCIe defines package.
REQ-027 Round-robin winner selection SHALL be one sub-module, rr_select (inputs request vector and last index; output winner index and valid).

Verification
REQ-028 After reset, drive i_req=3'b110 -> o_grant=3'b010 one cycle later and o_eg_command equals requester 1's command.
REQ-029 With PRIO0=1, hold i_req=3'b111 for three transactions -> grant order 0,0,0; with PRIO0=0 -> grant order 0,1,2.
REQ-030 During ACTIVE for requester 2, pulse i_eg_fifo_stb 4 times -> o_fifo_stb[2] pulses 4 times and o_fifo_stb[1:0] stays 0; o_eg_fifo_data equals i_fifo_data slice 2.
REQ-031 Change requester 1's i_address from 0x1000 to 0x2000 mid-ACTIVE -> o_eg_address holds 0x1000 until DONE.
REQ-032 Hold i_eg_finished=1 for 3 cycles -> o_done pulses once; IDLE entered only after i_eg_finished=0; assert rst mid-ACTIVE -> o_eg_enable=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pcie_egress_arbiter_pkg.sv
// Shared PCIe egress definitions: arbiter state encoding, TLP header and
// FIFO field widths, and the latched header record handed to the engine.
package pcie_egress_arbiter_pkg;

    localparam int CMD_W       = 8;
    localparam int FLAGS_W     = 14;
    localparam int ADDR_W      = 32;
    localparam int RID_W       = 16;
    localparam int TAG_W       = 8;
    localparam int FIFO_SIZE_W = 24;
    localparam int FIFO_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [CMD_W-1:0]   command;
        logic [FLAGS_W-1:0] flags;
        logic [ADDR_W-1:0]  address;
        logic [RID_W-1:0]   requester_id;
        logic [TAG_W-1:0]   tag;
    } eg_header_t;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcie_egress_arbiter_rr_select.sv
// Round-robin winner selection: scans the request vector starting one past
// the previously served requester and wraps from NUM_REQ-1 back to 0.
module rr_select #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // First requesting index after last_idx, in wrap-around order.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        idx   = '0;
        valid = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            int cand;
            cand = int'(last_idx) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!valid && req[cand]) begin
                idx   = IDX_W'(cand);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_egress_arbiter.sv
// Egress arbiter: shares one PCIe egress engine among NUM_REQ requesters.
// Requester 0 (completions) may take strict priority; the rest are served
// round-robin. The winner's header is latched for the whole transaction and
// its FIFO handshake is muxed through to the engine while a grant is held.
module pcie_egress_arbiter
    import pcie_egress_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PRIO0   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ*CMD_W-1:0]       i_command,
    input  logic [NUM_REQ*FLAGS_W-1:0]     i_flags,
    input  logic [NUM_REQ*ADDR_W-1:0]      i_address,
    input  logic [NUM_REQ*RID_W-1:0]       i_requester_id,
    input  logic [NUM_REQ*TAG_W-1:0]       i_tag,
    input  logic [NUM_REQ-1:0]             i_fifo_rdy,
    input  logic [NUM_REQ*FIFO_SIZE_W-1:0] i_fifo_size,
    input  logic [NUM_REQ*FIFO_DATA_W-1:0] i_fifo_data,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic [NUM_REQ-1:0]             o_done,
    output logic [NUM_REQ-1:0]             o_fifo_act,
    output logic [NUM_REQ-1:0]             o_fifo_stb,
    output logic                           o_eg_enable,
    input  logic                           i_eg_finished,
    output logic [CMD_W-1:0]               o_eg_command,
    output logic [FLAGS_W-1:0]             o_eg_flags,
    output logic [ADDR_W-1:0]              o_eg_address,
    output logic [RID_W-1:0]               o_eg_requester_id,
    output logic [TAG_W-1:0]               o_eg_tag,
    output logic                           o_eg_fifo_rdy,
    output logic [FIFO_SIZE_W-1:0]         o_eg_fifo_size,
    output logic [FIFO_DATA_W-1:0]         o_eg_fifo_data,
    input  logic                           i_eg_fifo_act,
    input  logic                           i_eg_fifo_stb,
    output logic                           o_busy
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_valid;
    logic [IDX_W-1:0] win_idx;
    eg_header_t       hdr;
    eg_header_t       win_hdr;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req      (i_req),
        .last_idx (last_idx),
        .idx      (rr_idx),
        .valid    (rr_valid)
    );

    // Winner: requester 0 overrides round-robin when priority is enabled.
    always_comb begin
        if ((PRIO0 != 0) && i_req[0]) begin
            win_idx = '0;
        end else begin
            win_idx = rr_idx;
        end
    end

    // Gather the winner's header fields from the packed request buses.
    always_comb begin
        win_hdr = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (IDX_W'(r) == win_idx) begin
                win_hdr.command      = i_command[r*CMD_W +: CMD_W];
                win_hdr.flags        = i_flags[r*FLAGS_W +: FLAGS_W];
                win_hdr.address      = i_address[r*ADDR_W +: ADDR_W];
                win_hdr.requester_id = i_requester_id[r*RID_W +: RID_W];
                win_hdr.tag          = i_tag[r*TAG_W +: TAG_W];
            end
        end
    end

    // Arbitration FSM with registered grant, done, enable, busy and header.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the header is a handful of flops, not a memory, so it is
            // cleared here to keep every engine-facing output at 0 in reset.
            state       <= ST_IDLE;
            idx         <= '0;
            last_idx    <= IDX_W'(NUM_REQ - 1);
            hdr         <= '0;
            o_grant     <= '0;
            o_done      <= '0;
            o_eg_enable <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (state)
                ST_IDLE: begin
                    if (rr_valid) begin
                        idx         <= win_idx;
                        hdr         <= win_hdr;
                        o_grant     <= NUM_REQ'(1) << win_idx;
                        o_eg_enable <= 1'b1;
                        o_busy      <= 1'b1;
                        state       <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (i_eg_finished) begin
                        o_eg_enable <= 1'b0;
                        o_done      <= NUM_REQ'(1) << idx;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_done <= '0;
                    if (!i_eg_finished) begin
                        last_idx <= idx;
                        o_grant  <= '0;
                        o_busy   <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    o_grant     <= '0;
                    o_done      <= '0;
                    o_eg_enable <= 1'b0;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_eg_command      = hdr.command;
    assign o_eg_flags        = hdr.flags;
    assign o_eg_address      = hdr.address;
    assign o_eg_requester_id = hdr.requester_id;
    assign o_eg_tag          = hdr.tag;

    // FIFO path mux: connects only the granted requester to the engine.
    always_comb begin
        o_eg_fifo_rdy  = 1'b0;
        o_eg_fifo_size = '0;
        o_eg_fifo_data = '0;
        o_fifo_act     = '0;
        o_fifo_stb     = '0;
        if (state != ST_IDLE) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (IDX_W'(r) == idx) begin
                    o_eg_fifo_rdy  = i_fifo_rdy[r];
                    o_eg_fifo_size = i_fifo_size[r*FIFO_SIZE_W +: FIFO_SIZE_W];
                    o_eg_fifo_data = i_fifo_data[r*FIFO_DATA_W +: FIFO_DATA_W];
                    o_fifo_act[r]  = i_eg_fifo_act;
                    o_fifo_stb[r]  = i_eg_fifo_stb;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcie_egress_arbiter.sv
// Directed bench for pcie_egress_arbiter. Two instances share all stimulus:
// dut uses strict priority for requester 0, dut_rr uses pure round-robin.
module tb_pcie_egress_arbiter;
    import pcie_egress_arbiter_pkg::*;

    localparam int N = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [N-1:0]           i_req = '0;
    logic [N*CMD_W-1:0]     i_command = '0;
    logic [N*FLAGS_W-1:0]   i_flags = '0;
    logic [N*ADDR_W-1:0]    i_address = '0;
    logic [N*RID_W-1:0]     i_requester_id = '0;
    logic [N*TAG_W-1:0]     i_tag = '0;
    logic [N-1:0]           i_fifo_rdy = '0;
    logic [N*FIFO_SIZE_W-1:0] i_fifo_size = '0;
    logic [N*FIFO_DATA_W-1:0] i_fifo_data = '0;
    logic                   i_eg_finished = 1'b0;
    logic                   i_eg_fifo_act = 1'b0;
    logic                   i_eg_fifo_stb = 1'b0;

    logic [N-1:0]           o_grant, o_done, o_fifo_act, o_fifo_stb;
    logic                   o_eg_enable, o_eg_fifo_rdy, o_busy;
    logic [CMD_W-1:0]       o_eg_command;
    logic [FLAGS_W-1:0]     o_eg_flags;
    logic [ADDR_W-1:0]      o_eg_address;
    logic [RID_W-1:0]       o_eg_requester_id;
    logic [TAG_W-1:0]       o_eg_tag;
    logic [FIFO_SIZE_W-1:0] o_eg_fifo_size;
    logic [FIFO_DATA_W-1:0] o_eg_fifo_data;

    logic [N-1:0]           b_grant, b_done, b_fifo_act, b_fifo_stb;
    logic                   b_eg_enable, b_eg_fifo_rdy, b_busy;
    logic [CMD_W-1:0]       b_eg_command;
    logic [FLAGS_W-1:0]     b_eg_flags;
    logic [ADDR_W-1:0]      b_eg_address;
    logic [RID_W-1:0]       b_eg_requester_id;
    logic [TAG_W-1:0]       b_eg_tag;
    logic [FIFO_SIZE_W-1:0] b_eg_fifo_size;
    logic [FIFO_DATA_W-1:0] b_eg_fifo_data;

    int checks = 0;
    int failures = 0;
    int stb_seen = 0;

    pcie_egress_arbiter #(.NUM_REQ(N), .PRIO0(1)) dut (
        .clk(clk), .rst(rst), .i_req(i_req),
        .i_command(i_command), .i_flags(i_flags), .i_address(i_address),
        .i_requester_id(i_requester_id), .i_tag(i_tag),
        .i_fifo_rdy(i_fifo_rdy), .i_fifo_size(i_fifo_size), .i_fifo_data(i_fifo_data),
        .o_grant(o_grant), .o_done(o_done), .o_fifo_act(o_fifo_act), .o_fifo_stb(o_fifo_stb),
        .o_eg_enable(o_eg_enable), .i_eg_finished(i_eg_finished),
        .o_eg_command(o_eg_command), .o_eg_flags(o_eg_flags), .o_eg_address(o_eg_address),
        .o_eg_requester_id(o_eg_requester_id), .o_eg_tag(o_eg_tag),
        .o_eg_fifo_rdy(o_eg_fifo_rdy), .o_eg_fifo_size(o_eg_fifo_size),
        .o_eg_fifo_data(o_eg_fifo_data), .i_eg_fifo_act(i_eg_fifo_act),
        .i_eg_fifo_stb(i_eg_fifo_stb), .o_busy(o_busy)
    );

    pcie_egress_arbiter #(.NUM_REQ(N), .PRIO0(0)) dut_rr (
        .clk(clk), .rst(rst), .i_req(i_req),
        .i_command(i_command), .i_flags(i_flags), .i_address(i_address),
        .i_requester_id(i_requester_id), .i_tag(i_tag),
        .i_fifo_rdy(i_fifo_rdy), .i_fifo_size(i_fifo_size), .i_fifo_data(i_fifo_data),
        .o_grant(b_grant), .o_done(b_done), .o_fifo_act(b_fifo_act), .o_fifo_stb(b_fifo_stb),
        .o_eg_enable(b_eg_enable), .i_eg_finished(i_eg_finished),
        .o_eg_command(b_eg_command), .o_eg_flags(b_eg_flags), .o_eg_address(b_eg_address),
        .o_eg_requester_id(b_eg_requester_id), .o_eg_tag(b_eg_tag),
        .o_eg_fifo_rdy(b_eg_fifo_rdy), .o_eg_fifo_size(b_eg_fifo_size),
        .o_eg_fifo_data(b_eg_fifo_data), .i_eg_fifo_act(i_eg_fifo_act),
        .i_eg_fifo_stb(i_eg_fifo_stb), .o_busy(b_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction while i_req is held: grant, finish, back to IDLE.
    task automatic txn(input string tag, input logic [N-1:0] exp_a,
                       input logic [N-1:0] exp_b);
        step();
        check({tag, "_grant_prio"}, 64'(o_grant), 64'(exp_a));
        check({tag, "_grant_rr"}, 64'(b_grant), 64'(exp_b));
        i_eg_finished = 1'b1;
        step();
        i_eg_finished = 1'b0;
        step();
        check({tag, "_idle_gap"}, 64'({o_busy, o_grant}), 64'(0));
    endtask

    initial begin
        for (int r = 0; r < N; r++) begin
            i_command[r*CMD_W +: CMD_W]               = CMD_W'(8'h10 + r);
            i_flags[r*FLAGS_W +: FLAGS_W]             = FLAGS_W'(14'h100 + r);
            i_requester_id[r*RID_W +: RID_W]          = RID_W'(16'h0100 + r);
            i_tag[r*TAG_W +: TAG_W]                   = TAG_W'(8'h20 + r);
            i_fifo_size[r*FIFO_SIZE_W +: FIFO_SIZE_W] = FIFO_SIZE_W'(24'h000100 * (r + 1));
            i_fifo_data[r*FIFO_DATA_W +: FIFO_DATA_W] = FIFO_DATA_W'(32'hD000_0000 + r);
        end
        i_address[0*ADDR_W +: ADDR_W] = 32'h0000_0A00;
        i_address[1*ADDR_W +: ADDR_W] = 32'h0000_1000;
        i_address[2*ADDR_W +: ADDR_W] = 32'h0000_3000;

        // Reset state, including edges seen while reset is still held.
        step();
        step();
        check("rst_grant", 64'(o_grant), 64'(0));
        check("rst_enable_busy_done", 64'({o_eg_enable, o_busy, o_done}), 64'(0));
        check("rst_header", 64'({o_eg_command, o_eg_address}), 64'(0));
        i_req = 3'b110;
        step();
        step();
        check("rst_held_no_grant", 64'({o_grant, o_busy, o_eg_enable}), 64'(0));

        // First edge with reset released grants requester 1.
        rst = 1'b1;
        step();
        check("first_grant", 64'(o_grant), 64'(3'b010));
        check("first_grant_rr", 64'(b_grant), 64'(3'b010));
        check("first_enable_busy", 64'({o_eg_enable, o_busy}), 64'(2'b11));
        check("first_command", 64'(o_eg_command), 64'(8'h11));
        check("first_flags", 64'(o_eg_flags), 64'(14'h101));
        check("first_rid_tag", 64'({o_eg_requester_id, o_eg_tag}), 64'({16'h0101, 8'h21}));
        check("first_address", 64'(o_eg_address), 64'(32'h1000));

        // Requester 1 changes its address and drops its request mid-ACTIVE.
        i_address[1*ADDR_W +: ADDR_W] = 32'h0000_2000;
        i_req = 3'b000;
        i_fifo_rdy = 3'b010;
        step();
        step();
        check("active_addr_held", 64'(o_eg_address), 64'(32'h1000));
        check("active_grant_held", 64'({o_grant, o_eg_enable}), 64'({3'b010, 1'b1}));
        check("active_fifo_rdy", 64'(o_eg_fifo_rdy), 64'(1));
        check("active_fifo_size", 64'(o_eg_fifo_size), 64'(24'h000200));

        // Finished held for three cycles: one done pulse, IDLE only after release.
        i_eg_finished = 1'b1;
        step();
        check("done_enable_low", 64'(o_eg_enable), 64'(0));
        check("done_pulse", 64'(o_done), 64'(3'b010));
        check("done_addr_held", 64'(o_eg_address), 64'(32'h1000));
        step();
        check("done_pulse_gone", 64'(o_done), 64'(0));
        check("done_wait_busy", 64'({o_busy, o_grant}), 64'({1'b1, 3'b010}));
        step();
        check("done_wait_busy2", 64'({o_busy, o_grant, o_done}), 64'({1'b1, 3'b010, 3'b000}));
        i_eg_finished = 1'b0;
        step();
        check("back_idle", 64'({o_busy, o_grant, o_done, o_eg_enable}), 64'(0));

        // Finished while IDLE is ignored; IDLE FIFO path stays quiet.
        i_eg_finished = 1'b1;
        i_eg_fifo_act = 1'b1;
        i_eg_fifo_stb = 1'b1;
        i_fifo_rdy = 3'b111;
        step();
        step();
        check("idle_finished_ignored", 64'({o_busy, o_done, o_eg_enable}), 64'(0));
        check("idle_fifo_quiet", 64'({o_fifo_act, o_fifo_stb, o_eg_fifo_rdy}), 64'(0));
        i_eg_finished = 1'b0;
        i_eg_fifo_act = 1'b0;
        i_eg_fifo_stb = 1'b0;

        // Fresh reset, then all three request continuously.
        rst = 1'b0;
        #1;
        i_req = 3'b111;
        step();
        rst = 1'b1;
        txn("prio_t1", 3'b001, 3'b001);
        txn("prio_t2", 3'b001, 3'b010);
        txn("prio_t3", 3'b001, 3'b100);
        check("rr_t3_command", 64'(b_eg_command), 64'(8'h12));

        // Requester 2 alone: FIFO strobes reach only its slice.
        i_req = 3'b100;
        i_fifo_rdy = 3'b100;
        step();
        check("r2_grant", 64'(o_grant), 64'(3'b100));
        check("r2_fifo_rdy", 64'(o_eg_fifo_rdy), 64'(1));
        check("r2_fifo_data", 64'(o_eg_fifo_data), 64'(32'hD000_0002));
        check("r2_fifo_size", 64'(o_eg_fifo_size), 64'(24'h000300));
        i_eg_fifo_act = 1'b1;
        #1;
        check("r2_fifo_act", 64'(o_fifo_act), 64'(3'b100));
        for (int p = 0; p < 4; p++) begin
            i_eg_fifo_stb = 1'b1;
            #2;
            if (o_fifo_stb[2]) stb_seen++;
            check("r2_stb_high_others_low", 64'(o_fifo_stb[1:0]), 64'(0));
            i_eg_fifo_stb = 1'b0;
            #2;
            check("r2_stb_low", 64'(o_fifo_stb), 64'(0));
            step();
        end
        check("r2_stb_pulse_count", 64'(stb_seen), 64'(4));
        check("r2_still_enabled", 64'({o_eg_enable, o_grant}), 64'({1'b1, 3'b100}));

        // Asynchronous reset mid-ACTIVE clears outputs before any edge.
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_enable", 64'(o_eg_enable), 64'(0));
        check("async_rst_grant_busy", 64'({o_grant, o_busy}), 64'(0));
        check("async_rst_fifo", 64'({o_fifo_act, o_eg_fifo_rdy, o_eg_fifo_data}), 64'(0));
        i_eg_fifo_act = 1'b0;
        i_req = 3'b000;
        step();
        rst = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
